// File: rtl/aoc_day7_pkg.sv
// Shared definitions for the day-7 beam-splitter pipeline: ASCII codes,
// status encodings, loader FSM states and default grid geometry.
package aoc_day7_pkg;

  localparam int DEF_WIDTH  = 141;
  localparam int DEF_HEIGHT = 141;
  localparam int MIDDLE     = 70;

  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_BAD_CHAR        = 3'd1,
    ERR_WIDTH_MISMATCH  = 3'd2,
    ERR_HEIGHT_MISMATCH = 3'd3,
    ERR_START           = 3'd4
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARSE = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage : aoc_day7_pkg

// File: rtl/aoc_char_decode.sv
// Combinational classifier for one puzzle-text byte.
module aoc_char_decode
  import aoc_day7_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_grid,
  output logic       is_splitter,
  output logic       is_start,
  output logic       is_lf,
  output logic       is_cr,
  output logic       is_bad
);

  logic is_dot;

  assign is_dot      = (ch == CH_DOT);
  assign is_splitter = (ch == CH_CARET);
  assign is_start    = (ch == CH_S);
  assign is_lf       = (ch == CH_LF);
  assign is_cr       = (ch == CH_CR);
  assign is_grid     = is_dot | is_splitter | is_start;
  assign is_bad      = ~(is_grid | is_lf | is_cr);

endmodule : aoc_char_decode

// File: rtl/aoc_grid_loader.sv
// Streaming ASCII grid parser: turns text lines into WIDTH-bit splitter rows.
// Optional '^' counter output enabled by AOC_GRID_LOADER_CARET_COUNT_EN.
module aoc_grid_loader
  import aoc_day7_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ROW_AW = 8,
  parameter int COL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              row_we,
  output logic [ROW_AW-1:0] row_addr,
  output logic [WIDTH-1:0]  row_data,
  output logic [COL_W-1:0]  start_col,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
`ifdef AOC_GRID_LOADER_CARET_COUNT_EN
  ,
  output logic [31:0]       caret_count
`endif
);

  // Row counter carries one extra bit so that row == HEIGHT is representable.
  localparam int RW = ROW_AW + 1;

  state_e            state_q, state_d;
  err_code_e         err_code_q, err_code_d;
  err_code_e         byte_err;
  logic [COL_W-1:0]  col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              start_seen_q, start_seen_d;
  logic [WIDTH-1:0]  bitmap_q, bitmap_d;
  logic [WIDTH-1:0]  bitmap_shift;
  logic [COL_W-1:0]  start_col_q, start_col_d;
  logic              row_we_q, row_we_d;
  logic [ROW_AW-1:0] row_addr_q, row_addr_d;
  logic [WIDTH-1:0]  row_data_q, row_data_d;
  logic              accept;
  logic              arm;
  logic              row_end;

  logic cls_grid, cls_splitter, cls_start, cls_lf, cls_cr, cls_bad;

  aoc_char_decode u_decode (
    .ch          (in_data),
    .is_grid     (cls_grid),
    .is_splitter (cls_splitter),
    .is_start    (cls_start),
    .is_lf       (cls_lf),
    .is_cr       (cls_cr),
    .is_bad      (cls_bad)
  );

  assign in_ready = (state_q == ST_PARSE);
  assign accept   = in_valid && in_ready;
  assign arm      = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

  // Characters enter at the MSB; after WIDTH shifts column x sits at bit x.
  assign bitmap_shift = {cls_splitter, bitmap_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    err_code_d   = err_code_q;
    col_d        = col_q;
    row_d        = row_q;
    start_seen_d = start_seen_q;
    bitmap_d     = bitmap_q;
    start_col_d  = start_col_q;
    row_we_d     = 1'b0;
    row_addr_d   = row_addr_q;
    row_data_d   = row_data_q;
    byte_err     = ERR_NONE;
    row_end      = 1'b0;

    unique case (state_q)
      ST_PARSE: begin
        if (accept) begin
          if (cls_bad) begin
            byte_err = ERR_BAD_CHAR;
          end else if (cls_grid) begin
            if (col_q == COL_W'(WIDTH)) begin
              byte_err = ERR_WIDTH_MISMATCH;
            end else if (cls_start && start_seen_q) begin
              byte_err = ERR_START;
            end else begin
              bitmap_d = bitmap_shift;
              col_d    = col_q + COL_W'(1);
              if (cls_start) begin
                start_seen_d = 1'b1;
                start_col_d  = col_q;
              end
              // A file that ends without a newline still closes its last row.
              row_end = in_last && (col_q == COL_W'(WIDTH - 1));
            end
          end else if (cls_lf) begin
            if (col_q == COL_W'(WIDTH)) begin
              row_end = 1'b1;
            end else if (col_q != '0) begin
              byte_err = ERR_WIDTH_MISMATCH;
            end
          end else if (cls_cr) begin
            // Dropped so that CRLF files parse like LF files.
          end

          if (byte_err == ERR_NONE && row_end && row_q == RW'(HEIGHT)) begin
            byte_err = ERR_HEIGHT_MISMATCH;
          end

          if (byte_err != ERR_NONE) begin
            state_d    = ST_ERR;
            err_code_d = byte_err;
          end else begin
            if (row_end) begin
              row_we_d   = 1'b1;
              row_addr_d = row_q[ROW_AW-1:0];
              row_data_d = (cls_grid) ? bitmap_shift : bitmap_q;
              row_d      = row_q + RW'(1);
              col_d      = '0;
              bitmap_d   = '0;
            end
            if (in_last) begin
              state_d = ST_CHECK;
            end
          end
        end
      end

      // The final row write is on the port this cycle; the end check follows it.
      ST_CHECK: begin
        if (row_q == RW'(HEIGHT) && start_seen_q) begin
          state_d = ST_DONE;
        end else if (!start_seen_q) begin
          state_d    = ST_ERR;
          err_code_d = ERR_START;
        end else begin
          state_d    = ST_ERR;
          err_code_d = ERR_HEIGHT_MISMATCH;
        end
      end

      default: begin
        if (arm) begin
          state_d      = ST_PARSE;
          err_code_d   = ERR_NONE;
          col_d        = '0;
          row_d        = '0;
          start_seen_d = 1'b0;
          bitmap_d     = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      err_code_q   <= ERR_NONE;
      col_q        <= '0;
      row_q        <= '0;
      start_seen_q <= 1'b0;
      bitmap_q     <= '0;
      start_col_q  <= '0;
      row_we_q     <= 1'b0;
      row_addr_q   <= '0;
      row_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      col_q        <= col_d;
      row_q        <= row_d;
      start_seen_q <= start_seen_d;
      bitmap_q     <= bitmap_d;
      start_col_q  <= start_col_d;
      row_we_q     <= row_we_d;
      row_addr_q   <= row_addr_d;
      row_data_q   <= row_data_d;
    end
  end

  assign row_we    = row_we_q;
  assign row_addr  = row_addr_q;
  assign row_data  = row_data_q;
  assign start_col = start_col_q;
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);
  assign err_code  = err_code_q;

`ifdef AOC_GRID_LOADER_CARET_COUNT_EN
  logic [31:0] caret_count_q, caret_count_d;

  always_comb begin
    caret_count_d = caret_count_q;
    if (arm) begin
      caret_count_d = '0;
    end else if (accept && cls_splitter) begin
      caret_count_d = caret_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      caret_count_q <= '0;
    end else begin
      caret_count_q <= caret_count_d;
    end
  end

  assign caret_count = caret_count_q;
`endif

endmodule : aoc_grid_loader

// File: tb/tb_aoc_grid_loader.sv
// Directed self-checking bench for aoc_grid_loader on a 5x3 grid.
module tb_aoc_grid_loader;

  localparam int WIDTH  = 5;
  localparam int HEIGHT = 3;
  localparam int ROW_AW = 2;
  localparam int COL_W  = 3;

  localparam string CLEAN = "..S..\n.^...\n^.^.^\n";

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              row_we;
  logic [ROW_AW-1:0] row_addr;
  logic [WIDTH-1:0]  row_data;
  logic [COL_W-1:0]  start_col;
  logic              done;
  logic              error;
  logic [2:0]        err_code;
`ifdef AOC_GRID_LOADER_CARET_COUNT_EN
  logic [31:0]       caret_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [ROW_AW-1:0] wr_addr[$];
  logic [WIDTH-1:0]  wr_data[$];

  aoc_grid_loader #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ROW_AW (ROW_AW),
    .COL_W  (COL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .row_we    (row_we),
    .row_addr  (row_addr),
    .row_data  (row_data),
    .start_col (start_col),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
`ifdef AOC_GRID_LOADER_CARET_COUNT_EN
    ,
    .caret_count (caret_count)
`endif
  );

  always #5 clk = ~clk;

  // Row-memory model: log every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (row_we === 1'b1) begin
      wr_addr.push_back(row_addr);
      wr_data.push_back(row_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i], last && (i == s.len() - 1));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_status();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [ROW_AW-1:0] ea, input logic [WIDTH-1:0] ed);
    logic [ROW_AW-1:0] a;
    logic [WIDTH-1:0]  d;
    a = 'x;
    d = 'x;
    if (idx < wr_data.size()) begin
      a = wr_addr[idx];
      d = wr_data[idx];
    end
    check({tag, "_addr"}, 32'(a), 32'(ea));
    check({tag, "_data"}, 32'(d), 32'(ed));
  endtask

  task automatic check_clean(input string tag, input int base);
    check({tag, "_nwr"}, wr_data.size(), base + 3);
    check_write({tag, "_r0"}, base + 0, 2'd0, 5'h00);
    check_write({tag, "_r1"}, base + 1, 2'd1, 5'h02);
    check_write({tag, "_r2"}, base + 2, 2'd2, 5'h15);
    check({tag, "_start_col"}, 32'(start_col), 32'd2);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  task automatic run_error(input string tag, input string s, input logic last,
                           input int exp_code, input int exp_writes);
    int base;
    base = wr_data.size();
    pulse_start();
    send_str(s, last);
    wait_status();
    check({tag, "_error"}, 32'(error), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'(exp_code));
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, wr_data.size() - base, exp_writes);
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_row_we", 32'(row_we), 32'd0);
    check("rst_row_data", 32'(row_data), 32'd0);
    check("rst_status", 32'({done, error, err_code}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean grid with exact done timing
    base = wr_data.size();
    pulse_start();
    check("parse_in_ready", 32'(in_ready), 32'd1);
    send_str(CLEAN, 1'b1);
    @(negedge clk);
    check("clean_last_we", 32'(row_we), 32'd1);
    check("clean_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("clean_done", 32'(done), 32'd1);
    check("clean_error", 32'(error), 32'd0);
    check("clean_in_ready", 32'(in_ready), 32'd0);
    check_clean("clean", base);
`ifdef AOC_GRID_LOADER_CARET_COUNT_EN
    check("clean_carets", caret_count, 32'd4);
`endif

    // CRLF line endings, no trailing newline
    base = wr_data.size();
    pulse_start();
    send_str("..S..\r\n.....\r\n....^", 1'b1);
    wait_status();
    check("crlf_done", 32'(done), 32'd1);
    check("crlf_err_code", 32'(err_code), 32'd0);
    check("crlf_nwr", wr_data.size() - base, 3);
    check_write("crlf_r1", base + 1, 2'd1, 5'h00);
    check_write("crlf_r2", base + 2, 2'd2, 5'h10);

    // Bad character on row 1: error the very next cycle, row 1 never written
    base = wr_data.size();
    pulse_start();
    send_str("..S..\n.^x", 1'b0);
    @(negedge clk);
    check("bad_error", 32'(error), 32'd1);
    check("bad_code", 32'(err_code), 32'd1);
    check("bad_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bad_nwr", wr_data.size() - base, 1);
    check_write("bad_r0", base, 2'd0, 5'h00);

    // Width, start and height faults
    run_error("short_row", "..S.\n", 1'b0, 2, 0);
    run_error("long_row", "......", 1'b0, 2, 0);
    run_error("two_s", "S.S", 1'b0, 4, 0);
    run_error("no_s", ".....\n.^...\n.....\n", 1'b1, 4, 3);
    run_error("extra_row", {CLEAN, ".....\n"}, 1'b1, 3, 3);
    run_error("few_rows", "..S..\n", 1'b1, 3, 1);

    // Mid-parse reset after 7 bytes, then recovery
    pulse_start();
    send_str("..S..\n.", 1'b0);
    rst = 1'b1;
    #1;
    base = wr_data.size();
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_start_col", 32'(start_col), 32'd0);
    @(negedge clk);
    check("mid_rst_outputs",
          32'({row_we, row_addr, row_data, done, error, err_code}), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_nwr", wr_data.size() - base, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = wr_data.size();
    pulse_start();
    send_str(CLEAN, 1'b1);
    wait_status();
    check("recover_done", 32'(done), 32'd1);
    check_clean("recover", base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_aoc_grid_loader

// File: doc/aoc_grid_loader.md
Name: aoc_grid_loader

Overview:
- Streaming ASCII parser upstream of the day-7 beam-splitter simulator.
- Consumes the raw puzzle text one byte per cycle over a valid/ready stream. Converts each text line into a WIDTH-bit splitter bitmap and writes it to the row memory the simulator reads.
- Reports the 'S' start column and a done/error status. The simulator's start is gated on done.

Parameters:
- WIDTH, 141, grid columns per row.
- HEIGHT, 141, grid rows.
- ROW_AW, 8, row address width; must satisfy 2^ROW_AW >= HEIGHT.
- COL_W, 8, column index width; must satisfy 2^COL_W > WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new parse.
- in_valid  in  1  input byte valid.
- in_data  in  8  ASCII byte.
- in_last  in  1  marks the final byte of the file; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- row_we  out  1  row memory write strobe, one cycle.
- row_addr  out  ROW_AW  row index, 0..HEIGHT-1.
- row_data  out  WIDTH  splitter bitmap; column x maps to bit x.
- start_col  out  COL_W  column of 'S'.
- done  out  1  parse completed successfully; level.
- error  out  1  parse failed; level.
- err_code  out  3  0 none, 1 BAD_CHAR, 2 WIDTH_MISMATCH, 3 HEIGHT_MISMATCH, 4 START_ERR.

Behaviour:
- Reset values: in_ready=0, row_we=0, row_addr=0, row_data=0, start_col=0, done=0, error=0, err_code=0. State is IDLE; col, row and start_seen counters are cleared.
- Reset mid-parse aborts immediately. Rows already written stay in memory; no further writes occur.
- States:
  - IDLE: in_ready=0. start goes to PARSE and clears col, row, start_seen, the shift bitmap, done, error and err_code.
  - PARSE: in_ready=1. A byte is accepted when in_valid && in_ready.
  - DONE: in_ready=0, done=1. start re-arms to PARSE.
  - ERR: in_ready=0, error=1, err_code held. start re-arms to PARSE.
- Byte decode in PARSE:
  - '.' (0x2E): bitmap[col]=0; col++.
  - '^' (0x5E): bitmap[col]=1; col++.
  - 'S' (0x53): bitmap[col]=0; start_col<=col; start_seen set; col++. If start_seen was already set, go to ERR with START_ERR.
  - CR (0x0D): ignored.
  - LF (0x0A) with col==0: blank line, ignored.
  - LF with col==WIDTH: end of row.
  - LF with any other col: ERR, WIDTH_MISMATCH.
  - Any other byte: ERR, BAD_CHAR.
  - A grid character arriving when col==WIDTH: ERR, WIDTH_MISMATCH.
- End of row:
  - The cycle after the terminating byte is accepted, row_we=1 for exactly one cycle, row_addr=row, and row_data holds the completed bitmap.
  - Then row++, col=0 and the bitmap clears.
  - Accepting a row terminator when row==HEIGHT is an ERR with HEIGHT_MISMATCH, and no write occurs.
- in_last:
  - If the last byte is a grid character that makes col==WIDTH, it is treated as an implicit LF.
  - After the last byte is processed, a pending row write completes first. Then the end check runs:
    - row==HEIGHT and start_seen: DONE.
    - !start_seen: ERR, START_ERR.
    - Otherwise: ERR, HEIGHT_MISMATCH.
- Error priority within one byte, highest first: BAD_CHAR > WIDTH_MISMATCH > START_ERR > HEIGHT_MISMATCH.
- A start pulse during PARSE is ignored.
- Throughput is one byte per cycle with no bubbles. The memory write port never backpressures.
- done/error assert 1 cycle after the last row write, or 2 cycles after acceptance of the last byte.

Optional Feature:
- Macro: AOC_GRID_LOADER_CARET_COUNT_EN.
- When defined:
  - Adds output caret_count [31:0], which counts accepted '^' bytes. It is cleared by reset and by start, and is valid when done=1.
  - Allows the testbench to cross-check the splitter total against the simulator result bound.
- When undefined: the port and its counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package aoc_day7_pkg holds:
  - the ASCII constants: CH_DOT, CH_CARET, CH_S, CH_LF, CH_CR;
  - the err_code encodings ERR_NONE..ERR_START;
  - the state encoding;
  - the default WIDTH, HEIGHT and MIDDLE (70).
- One sub-module, aoc_char_decode: combinational byte to {is_grid, is_splitter, is_start, is_lf, is_cr, is_bad}.
- The FSM, counters and bitmap shift register stay in the top module.

Test Plan:
- All tests use WIDTH=5, HEIGHT=3.
- Clean grid: stream "..S..\n.^...\n^.^.^\n" with in_last on the final LF, then:
  - 3 writes: addr0=0x00, addr1=0x02, addr2=0x15;
  - start_col=2;
  - done=1 two cycles after the last byte.
- CRLF and missing final newline: stream "..S..\r\n.....\r\n....^" with in_last on '^', then:
  - the third row is written as 0x10;
  - done=1, err_code=0.
- Bad character: 'x' as the 3rd byte of row 1 gives error=1, err_code=1, in_ready=0 the next cycle, and no write for row 1.
- Short row: "..S.\n" gives err_code=2 and no row_we pulse.
- Start errors: two 'S' in one row gives err_code=4. A full 3-row grid with no 'S' gives err_code=4 at in_last.
- Recovery and mid-parse reset:
  - Assert rst after 7 bytes: all outputs return to zero and in_ready=0.
  - Then pulse start, replay the clean grid, and expect done=1 with identical writes.
